// File: rtl/noc_port_queue_pkg.sv
// Shared NoC definitions: flit geometry and PMU counter sizing used by
// bridges, routers and port queues.
package noc_port_queue_pkg;

    localparam int NOC_DATA_WIDTH = 40;
    localparam int PMU_CNT_WIDTH  = 32;

    typedef logic [NOC_DATA_WIDTH-1:0] noc_data_t;

    typedef struct packed {
        logic      last;
        noc_data_t data;
    } noc_flit_t;

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream flit channel between NoC blocks; only TVALID/TREADY/TDATA/TLAST
// are carried.
interface axis_if #(
    parameter int DATA_WIDTH = 40
) ();

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/pmu_sat_counter.sv
// Event counter for the port PMU: counts up on inc, sticks at all-ones and
// returns to zero on clr (clr wins over a same-cycle inc).
module pmu_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/noc_port_queue.sv
// Flit queue in front of one router input port, with a small PMU that counts
// accepted flits/packets, input stall cycles and the occupancy high-water mark.
module noc_port_queue
    import noc_port_queue_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = PMU_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axis_if.slave                  s_axis,
    axis_if.master                 m_axis,
    input  logic                   pmu_clear,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_WIDTH-1:0]   pmu_flits,
    output logic [CNT_WIDTH-1:0]   pmu_packets,
    output logic [CNT_WIDTH-1:0]   pmu_stall_cycles,
    output logic [$clog2(DEPTH):0] pmu_max_occ
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr_next;
    logic [PTR_W-1:0]    rd_ptr_next;
    logic [PTR_W-1:0]    occ_next;
    logic [DATA_WIDTH:0] head;
    logic                full;
    logic                empty;
    logic                s_ready;
    logic                push;
    logic                pop;
    logic                stall;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign s_ready       = !full;
    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = !empty;

    assign push  = s_axis.tvalid && s_ready;
    assign pop   = m_axis.tready && !empty;
    assign stall = s_axis.tvalid && !s_ready;

    assign wr_ptr_next = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign rd_ptr_next = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;

    assign occupancy = wr_ptr - rd_ptr;
    assign occ_next  = wr_ptr_next - rd_ptr_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    assign head          = mem[rd_ptr[IDX_W-1:0]];
    assign m_axis.tdata  = head[DATA_WIDTH-1:0];
    assign m_axis.tlast  = head[DATA_WIDTH];

    // A clear restarts the high-water mark from whatever is queued right now.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pmu_max_occ <= '0;
        end else if (pmu_clear) begin
            pmu_max_occ <= occupancy;
        end else if (occ_next > pmu_max_occ) begin
            pmu_max_occ <= occ_next;
        end
    end

    pmu_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_flits (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clr   (pmu_clear),
        .count (pmu_flits)
    );

    pmu_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_packets (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push && s_axis.tlast),
        .clr   (pmu_clear),
        .count (pmu_packets)
    );

    pmu_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_stalls (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .clr   (pmu_clear),
        .count (pmu_stall_cycles)
    );

endmodule

// File: tb/tb_noc_port_queue.sv
// Directed bench for noc_port_queue at DEPTH=4: ordering, full/stall
// behaviour, streaming wrap, packet counting, PMU clear and mid-packet reset.
module tb_noc_port_queue;

    localparam int DW    = 40;
    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic          clk;
    logic          rst_n;
    logic          pmu_clear;
    logic [2:0]    occupancy;
    logic [CW-1:0] pmu_flits;
    logic [CW-1:0] pmu_packets;
    logic [CW-1:0] pmu_stall_cycles;
    logic [2:0]    pmu_max_occ;

    int assertCount;
    int failCount;
    int popCount;
    logic [7:0] lastMask;

    axis_if #(.DATA_WIDTH(DW)) s_if ();
    axis_if #(.DATA_WIDTH(DW)) m_if ();

    noc_port_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .pmu_clear        (pmu_clear),
        .occupancy        (occupancy),
        .pmu_flits        (pmu_flits),
        .pmu_packets      (pmu_packets),
        .pmu_stall_cycles (pmu_stall_cycles),
        .pmu_max_occ      (pmu_max_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                 input logic last, input logic mready);
        s_if.tvalid = valid;
        s_if.tdata  = data;
        s_if.tlast  = last;
        m_if.tready = mready;
    endtask

    task automatic pulseClear();
        pmu_clear = 1'b1;
        tick();
        pmu_clear = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        pmu_clear   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("reset_occ", 64'(occupancy), 64'd0);
        checkOutput("reset_tready", 64'(s_if.tready), 64'd1);
        checkOutput("reset_tvalid", 64'(m_if.tvalid), 64'd0);
        checkOutput("reset_flits", 64'(pmu_flits), 64'd0);
        checkOutput("reset_maxocc", 64'(pmu_max_occ), 64'd0);

        // Fill to full with the output blocked.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
            checkOutput("fill_tready", 64'(s_if.tready), 64'd1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("full_tready", 64'(s_if.tready), 64'd0);
        checkOutput("full_occ", 64'(occupancy), 64'd4);
        checkOutput("full_maxocc", 64'(pmu_max_occ), 64'd4);
        checkOutput("full_tvalid", 64'(m_if.tvalid), 64'd1);

        // Hold a flit against the full queue for 7 cycles.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, DW'('hAA), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("stall_cycles", 64'(pmu_stall_cycles), 64'd7);
        checkOutput("stall_head", 64'(m_if.tdata), 64'h01);
        checkOutput("stall_occ", 64'(occupancy), 64'd4);
        checkOutput("stall_flits", 64'(pmu_flits), 64'd4);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            checkOutput("drain_data", 64'(m_if.tdata), 64'(i));
            checkOutput("drain_tvalid", 64'(m_if.tvalid), 64'd1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("drain_occ", 64'(occupancy), 64'd0);
        checkOutput("drain_tvalid_low", 64'(m_if.tvalid), 64'd0);

        // Clear at empty, then stream 20 flits straight through.
        pulseClear();
        checkOutput("clr_flits", 64'(pmu_flits), 64'd0);
        checkOutput("clr_stalls", 64'(pmu_stall_cycles), 64'd0);
        checkOutput("clr_maxocc", 64'(pmu_max_occ), 64'd0);
        popCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, DW'('h100 + i), 1'b0, 1'b1);
            if (i > 0) begin
                checkOutput("stream_occ", 64'(occupancy), 64'd1);
                checkOutput("stream_data", 64'(m_if.tdata), 64'('h100 + i - 1));
            end
            if (m_if.tvalid) popCount++;
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("stream_last_data", 64'(m_if.tdata), 64'h113);
        if (m_if.tvalid) popCount++;
        tick();
        checkOutput("stream_pops", 64'(popCount), 64'd20);
        checkOutput("stream_occ_end", 64'(occupancy), 64'd0);
        checkOutput("stream_flits", 64'(pmu_flits), 64'd20);
        checkOutput("stream_maxocc", 64'(pmu_max_occ), 64'd1);

        // Packets of 1, 2 and 5 flits: TLAST on flits 1, 3 and 8.
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        pulseClear();
        lastMask = 8'h85;
        popCount = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) applyStimulus(1'b1, DW'('h200 + c), lastMask[c], 1'b1);
            else       applyStimulus(1'b0, '0, 1'b0, 1'b1);
            if (m_if.tvalid) begin
                checkOutput("pkt_data", 64'(m_if.tdata), 64'('h200 + popCount));
                checkOutput("pkt_tlast", 64'(m_if.tlast), 64'(lastMask[popCount]));
                popCount++;
            end
            tick();
        end
        checkOutput("pkt_pops", 64'(popCount), 64'd8);
        checkOutput("pkt_packets", 64'(pmu_packets), 64'd3);
        checkOutput("pkt_flits", 64'(pmu_flits), 64'd8);

        // Clear coinciding with a TLAST push at occupancy 2.
        applyStimulus(1'b1, DW'('h300), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, DW'('h301), 1'b0, 1'b0);
        tick();
        checkOutput("pre_clr_occ", 64'(occupancy), 64'd2);
        applyStimulus(1'b1, DW'('h302), 1'b1, 1'b0);
        pulseClear();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clrpush_flits", 64'(pmu_flits), 64'd0);
        checkOutput("clrpush_packets", 64'(pmu_packets), 64'd0);
        checkOutput("clrpush_stalls", 64'(pmu_stall_cycles), 64'd0);
        checkOutput("clrpush_maxocc", 64'(pmu_max_occ), 64'd2);
        checkOutput("clrpush_occ", 64'(occupancy), 64'd3);
        tick();
        checkOutput("hwm_follow", 64'(pmu_max_occ), 64'd3);

        // Simultaneous push/pop at occupancy 3 leaves a packet half-queued.
        applyStimulus(1'b1, DW'('h303), 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("pushpop_occ", 64'(occupancy), 64'd3);
        checkOutput("pushpop_head", 64'(m_if.tdata), 64'h301);
        checkOutput("pushpop_flits", 64'(pmu_flits), 64'd1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_tvalid", 64'(m_if.tvalid), 64'd0);
        checkOutput("midrst_tready", 64'(s_if.tready), 64'd1);
        checkOutput("midrst_occ", 64'(occupancy), 64'd0);
        checkOutput("midrst_flits", 64'(pmu_flits), 64'd0);
        checkOutput("midrst_packets", 64'(pmu_packets), 64'd0);
        checkOutput("midrst_stalls", 64'(pmu_stall_cycles), 64'd0);
        checkOutput("midrst_maxocc", 64'(pmu_max_occ), 64'd0);

        applyStimulus(1'b1, DW'('h3A5), 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("postrst_tvalid", 64'(m_if.tvalid), 64'd1);
        checkOutput("postrst_data", 64'(m_if.tdata), 64'h3A5);
        checkOutput("postrst_tlast", 64'(m_if.tlast), 64'd1);
        checkOutput("postrst_occ", 64'(occupancy), 64'd1);
        checkOutput("postrst_packets", 64'(pmu_packets), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
